// File: rtl/bcd_seq_multiplier.sv
// bcd_seq_multiplier: iterative shift-and-add multi-digit BCD multiplier (optional BCD_MUL_CHECK_EN flags non-BCD digits)
module bcd_seq_multiplier #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [8*DIGITS-1:0]   product,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int W = 8*DIGITS;
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, ADD = 2'd2, DONE = 2'd3;
  logic [1:0] state;
  logic [4*DIGITS-1:0] a_r, b_r;
  logic [W-1:0] acc, sum, ax;
  logic [2:0] idx;
  logic [3:0] cnt, dig;
  logic [4:0] t;
  logic c, bad;
  assign ax = {{(4*DIGITS){1'b0}}, a_r};
  assign dig = 4'(b_r >> {idx, 2'b00});
  always_comb begin
    c = 1'b0;
    t = '0;
    sum = '0;
    for (int i = 0; i < 2*DIGITS; i++) begin
      t = {1'b0, acc[4*i +: 4]} + {1'b0, ax[4*i +: 4]} + {4'b0, c};
      c = t > 5'd9;
      t = c ? t + 5'd6 : t;
      sum[4*i +: 4] = t[3:0];
    end
  end
  always_comb begin
    bad = 1'b0;
`ifdef BCD_MUL_CHECK_EN
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
`endif
  end
`ifndef BCD_MUL_CHECK_EN
  assign error = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      product <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef BCD_MUL_CHECK_EN
      error <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
`ifdef BCD_MUL_CHECK_EN
          error <= bad;
`endif
          if (bad) begin
            done <= 1'b1;
            product <= '0;
          end else begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            idx <= 3'(DIGITS-1);
            busy <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc << 4;
          cnt <= dig;
          state <= dig != 4'd0 ? ADD : idx == 3'd0 ? DONE : SHIFT;
          if (dig == 4'd0) idx <= idx - 3'd1;
        end
        ADD: begin
          acc <= sum;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= idx == 3'd0 ? DONE : SHIFT;
            idx <= idx - 3'd1;
          end
        end
        default: begin
          product <= acc;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_seq_multiplier.sv
// tb_bcd_seq_multiplier: randomized check of 1/2/4-digit instances against an integer-arithmetic model
module tb_bcd_seq_multiplier;
  logic clk = 1'b0, rst = 1'b1, st = 1'b0;
  logic [15:0] av = '0, bv = '0;
  int sel = 4;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] p1;
  logic [15:0] p2;
  logic [31:0] p4, p;
  logic [2:0] bz, dn, er;
  logic busy_s, done_s, err_s;
  always #5 clk = ~clk;
  bcd_seq_multiplier #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .start(st && sel == 1), .a(av[3:0]), .b(bv[3:0]),
    .product(p1), .busy(bz[0]), .done(dn[0]), .error(er[0]));
  bcd_seq_multiplier #(.DIGITS(2)) u2 (.clk(clk), .rst(rst), .start(st && sel == 2), .a(av[7:0]), .b(bv[7:0]),
    .product(p2), .busy(bz[1]), .done(dn[1]), .error(er[1]));
  bcd_seq_multiplier #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .start(st && sel == 4), .a(av), .b(bv),
    .product(p4), .busy(bz[2]), .done(dn[2]), .error(er[2]));
  always_comb begin
    p = sel == 1 ? {24'b0, p1} : sel == 2 ? {16'b0, p2} : p4;
    busy_s = sel == 1 ? bz[0] : sel == 2 ? bz[1] : bz[2];
    done_s = sel == 1 ? dn[0] : sel == 2 ? dn[1] : dn[2];
    err_s = sel == 1 ? er[0] : sel == 2 ? er[1] : er[2];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int bcd2int(input logic [15:0] x, input int d);
    int v = 0;
    for (int i = d-1; i >= 0; i--) v = v*10 + int'(x[4*i +: 4]);
    return v;
  endfunction
  function automatic logic [31:0] int2bcd(input int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic int dsum(input logic [15:0] y, input int d);
    int s = 0;
    for (int i = 0; i < d; i++) s += int'(y[4*i +: 4]);
    return s;
  endfunction
  function automatic bit has_bad(input logic [15:0] x, input logic [15:0] y, input int d);
    bit r = 0;
    for (int i = 0; i < d; i++) r |= (x[4*i +: 4] > 9) || (y[4*i +: 4] > 9);
    return r;
  endfunction
  function automatic logic [15:0] rnd_bcd(input int d);
    logic [15:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction
  task automatic run(input int d, input logic [15:0] x, input logic [15:0] y, input bit poke);
    int lat, k;
    bit bd;
    logic [31:0] exp;
    sel = d;
`ifdef BCD_MUL_CHECK_EN
    bd = has_bad(x, y, d);
`else
    bd = 0;
`endif
    lat = bd ? 0 : d + dsum(y, d) + 1;
    exp = bd ? 32'd0 : int2bcd(bcd2int(x, d) * bcd2int(y, d));
    @(negedge clk);
    av = x; bv = y; st = 1'b1;
    for (k = 0; k < 150; k++) begin
      @(posedge clk); #1;
      if (k == 0) st = 1'b0;
      if (done_s) break;
      if (poke && k == 2) begin st = 1'b1; av = rnd_bcd(d); bv = rnd_bcd(d); end
      if (poke && k == 3) st = 1'b0;
    end
    check($sformatf("lat d%0d %h*%h", d, x, y), k, lat);
    check($sformatf("prod d%0d %h*%h", d, x, y), p, exp);
    check("err", {31'b0, err_s}, {31'b0, bd});
    check("busy_at_done", {31'b0, busy_s}, 32'd0);
    @(posedge clk); #1;
    check("pulse", {31'b0, done_s}, 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_prod", p4, 0);
    check("rst_busy", {31'b0, busy_s}, 0);
    check("rst_done", {31'b0, done_s}, 0);
    check("rst_err", {31'b0, err_s}, 0);
    @(negedge clk) rst = 1'b0;
    run(2, 16'h0012, 16'h0034, 0);
    run(4, 16'h9999, 16'h9999, 0);
    run(4, 16'h1234, 16'h0000, 0);
    run(4, 16'h4321, 16'h0001, 1);
    run(4, 16'h5678, 16'h0908, 1);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++) run(1, 16'(i), 16'(j), 0);
`ifdef BCD_MUL_CHECK_EN
    run(4, 16'h00A5, 16'h0002, 0);
    run(4, 16'h0005, 16'h0002, 0);
`endif
    for (int i = 0; i < 40; i++) begin
      automatic int d = i % 3 == 0 ? 1 : i % 3 == 1 ? 2 : 4;
      run(d, rnd_bcd(d), rnd_bcd(d), i % 5 == 0);
    end
    sel = 4;
    @(negedge clk);
    av = 16'h9999; bv = 16'h9999; st = 1'b1;
    @(negedge clk) st = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_prod", p4, 0);
    check("midrst_busy", {31'b0, busy_s}, 0);
    check("midrst_done", {31'b0, done_s}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (done_s || busy_s) break;
    end
    check("midrst_idle", {30'b0, busy_s, done_s}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
